// File: rtl/servant_uart_loader.sv
// UART boot loader for the servant program RAM: receives a length-prefixed
// image over UART and writes it word-by-word through a Wishbone master.
module servant_uart_loader #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD        = 115200,
  parameter int depth       = 512,
  parameter int aw          = $clog2(depth)
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst_n,
  input  logic          i_uart_rx,
  output logic [aw-3:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic          i_wb_ack,
  output logic          o_cpu_rst,
  output logic          o_done,
  output logic          o_error,
  output logic [15:0]   o_word_cnt
);

  localparam int          DIV       = CLK_FREQ_HZ / BAUD;
  localparam logic [15:0] DIV_M1    = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1   = 16'(DIV / 2 - 1);
  localparam logic [15:0] MEM_WORDS = 16'(depth / 4);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR} ld_state_t;

  logic        rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_t   rx_state_r, rx_state_s;
  logic [15:0] rx_cnt_r, rx_cnt_s;
  logic [2:0]  rx_bit_r, rx_bit_s;
  logic [7:0]  rx_shift_r, rx_shift_s;
  logic        rx_valid_r, rx_valid_s, rx_ferr_r, rx_ferr_s;

  ld_state_t       state_r, state_s;
  logic [15:0]     len_r, len_s, len_hi_s;
  logic [1:0]      byte_idx_r, byte_idx_s;
  logic [23:0]     word_buf_r, word_buf_s;
  logic [aw-3:0]   adr_r, adr_s;
  logic [31:0]     dat_r, dat_s;
  logic            cyc_r, cyc_s, done_r, done_s, error_r, error_s, cpu_rst_r, cpu_rst_s;
  logic [15:0]     word_cnt_r, word_cnt_s;

  assign o_wb_adr   = adr_r;
  assign o_wb_dat   = dat_r;
  assign o_wb_sel   = 4'hF;
  assign o_wb_we    = 1'b1;
  assign o_wb_cyc   = cyc_r;
  assign o_cpu_rst  = cpu_rst_r;
  assign o_done     = done_r;
  assign o_error    = error_r;
  assign o_word_cnt = word_cnt_r;

  // RX synchroniser and receiver state registers
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      rx_meta_r  <= 1'b1;
      rx_sync_r  <= 1'b1;
      rx_prev_r  <= 1'b1;
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= 16'd0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'd0;
      rx_valid_r <= 1'b0;
      rx_ferr_r  <= 1'b0;
    end else begin
      rx_meta_r  <= i_uart_rx;
      rx_sync_r  <= rx_meta_r;
      rx_prev_r  <= rx_sync_r;
      rx_state_r <= rx_state_s;
      rx_cnt_r   <= rx_cnt_s;
      rx_bit_r   <= rx_bit_s;
      rx_shift_r <= rx_shift_s;
      rx_valid_r <= rx_valid_s;
      rx_ferr_r  <= rx_ferr_s;
    end
  end

  // RX next-state: mid-bit sampling, start bit rechecked at half a bit time
  always_comb begin
    rx_state_s = rx_state_r;
    rx_cnt_s   = rx_cnt_r + 16'd1;
    rx_bit_s   = rx_bit_r;
    rx_shift_s = rx_shift_r;
    rx_valid_s = 1'b0;
    rx_ferr_s  = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_s = 16'd0;
        if (rx_prev_r && !rx_sync_r) rx_state_s = RX_START;
        else                         rx_state_s = RX_IDLE;
      end
      RX_START: begin
        if (rx_cnt_r == HALF_M1) begin
          rx_cnt_s = 16'd0;
          rx_bit_s = 3'd0;
          if (!rx_sync_r) rx_state_s = RX_BITS;
          else            rx_state_s = RX_IDLE;
        end else begin
          rx_state_s = RX_START;
        end
      end
      RX_BITS: begin
        if (rx_cnt_r == DIV_M1) begin
          rx_cnt_s   = 16'd0;
          rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
          rx_bit_s   = rx_bit_r + 3'd1;
          if (rx_bit_r == 3'd7) rx_state_s = RX_STOP;
          else                  rx_state_s = RX_BITS;
        end else begin
          rx_state_s = RX_BITS;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == DIV_M1) begin
          rx_cnt_s   = 16'd0;
          rx_state_s = RX_IDLE;
          if (rx_sync_r) rx_valid_s = 1'b1;
          else           rx_ferr_s  = 1'b1;
        end else begin
          rx_state_s = RX_STOP;
        end
      end
      default: rx_state_s = RX_IDLE;
    endcase
  end

  // Load FSM state and registered bus/status outputs
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_r    <= LEN_LO;
      len_r      <= 16'd0;
      byte_idx_r <= 2'd0;
      word_buf_r <= 24'd0;
      adr_r      <= '0;
      dat_r      <= 32'd0;
      cyc_r      <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      cpu_rst_r  <= 1'b1;
      word_cnt_r <= 16'd0;
    end else begin
      state_r    <= state_s;
      len_r      <= len_s;
      byte_idx_r <= byte_idx_s;
      word_buf_r <= word_buf_s;
      adr_r      <= adr_s;
      dat_r      <= dat_s;
      cyc_r      <= cyc_s;
      done_r     <= done_s;
      error_r    <= error_s;
      cpu_rst_r  <= cpu_rst_s;
      word_cnt_r <= word_cnt_s;
    end
  end

  assign len_hi_s = {rx_shift_r, len_r[7:0]};

  // Load FSM next-state; a byte arriving while a write is pending is an overrun
  always_comb begin
    state_s    = state_r;
    len_s      = len_r;
    byte_idx_s = byte_idx_r;
    word_buf_s = word_buf_r;
    adr_s      = adr_r;
    dat_s      = dat_r;
    cyc_s      = cyc_r;
    done_s     = done_r;
    error_s    = error_r;
    cpu_rst_s  = cpu_rst_r;
    word_cnt_s = word_cnt_r;
    case (state_r)
      LEN_LO: begin
        if (rx_ferr_r) state_s = ERROR;
        else if (rx_valid_r) begin
          len_s   = {8'd0, rx_shift_r};
          state_s = LEN_HI;
        end else state_s = LEN_LO;
      end
      LEN_HI: begin
        if (rx_ferr_r) state_s = ERROR;
        else if (rx_valid_r) begin
          len_s = len_hi_s;
          if (len_hi_s == 16'd0 || len_hi_s > MEM_WORDS) state_s = ERROR;
          else begin
            state_s    = DATA;
            byte_idx_s = 2'd0;
          end
        end else state_s = LEN_HI;
      end
      DATA: begin
        if (rx_ferr_r) state_s = ERROR;
        else if (rx_valid_r) begin
          if (byte_idx_r == 2'd3) begin
            dat_s      = {rx_shift_r, word_buf_r};
            cyc_s      = 1'b1;
            byte_idx_s = 2'd0;
            state_s    = WRITE;
          end else begin
            word_buf_s = {rx_shift_r, word_buf_r[23:8]};
            byte_idx_s = byte_idx_r + 2'd1;
          end
        end else state_s = DATA;
      end
      WRITE: begin
        if (rx_ferr_r || rx_valid_r) state_s = ERROR;
        else if (i_wb_ack) begin
          cyc_s      = 1'b0;
          word_cnt_s = word_cnt_r + 16'd1;
          adr_s      = adr_r + (aw-2)'(1);
          if (word_cnt_r + 16'd1 == len_r) begin
            state_s   = DONE;
            done_s    = 1'b1;
            cpu_rst_s = 1'b0;
          end else state_s = DATA;
        end else state_s = WRITE;
      end
      DONE:    state_s = DONE;
      ERROR:   state_s = ERROR;
      default: state_s = ERROR;
    endcase
    if (state_s == ERROR) begin
      error_s = 1'b1;
      cyc_s   = 1'b0;
    end else begin
      error_s = error_r;
    end
  end

endmodule
